i2s_rx: RTL and testbench
=========================

# i2s_rx

I2S slave receiver: the receive-side counterpart of the team's I2S transmitter. Accepts external SCLK/LRCLK/SDATA, synchronises them into the `mclk` domain and de-serialises Philips-format frames. Produces one parallel sample per channel with a single-cycle valid strobe. Sits between an ADC/codec (or a loop-back of our own I2S TX) and the DSP/DDS datapath.

## Interface
**Parameters**
- `DATA_W`, default 16: bits captured per channel, MSB first.
- `SLOT_W`, default 32: maximum SCLK periods per LRCLK half-period; sizes the bit counter.

**Ports**
- `mclk`, in, 1: system clock; everything is sampled on its rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `sclk_i`, in, 1: bit clock, asynchronous to `mclk`.
- `lrclk_i`, in, 1: word select; low = left, high = right.
- `sdata_i`, in, 1: serial data, MSB first.
- `l_dout`, out, DATA_W: last complete left sample; holds between updates.
- `r_dout`, out, DATA_W: last complete right sample; holds between updates.
- `l_valid`, out, 1: one-cycle pulse when `l_dout` updates.
- `r_valid`, out, 1: one-cycle pulse when `r_dout` updates.
- `slot_err`, out, 1: one-cycle pulse when a half-frame ends before DATA_W bits are captured.

## Operation
- **Input conditioning:** `sclk_i`, `lrclk_i` and `sdata_i` each pass through a 2-FF synchroniser. A third flop on `sclk` gives `sclk_rise = s2 & ~s3`. All protocol actions occur only on `sclk_rise` cycles.
- **Channel-edge detection:** on each `sclk_rise`, sample synced LRCLK into `lr_q`. `lr_edge` is asserted when the new sample differs from `lr_q`.
- **Data alignment (Philips):** the bit sampled at the `lr_edge` rise still belongs to the previous word. The MSB is the next rise.
- **State machine:**
  - **WAIT_SYNC** (reset state): ignore data. On `lr_edge`, go to SHIFT and latch the channel as the new LRCLK level. This discards the partial frame after reset.
  - **SHIFT:** on each rise, shift `sdata` into `shreg` LSB-side and increment `bitcnt`.
    - When `bitcnt` reaches DATA_W, copy `shreg` to `l_dout` or `r_dout` per the latched channel, pulse the matching valid, and go to PAD.
    - If `lr_edge` arrives first, pulse `slot_err`, discard `shreg`, latch the new channel, clear `bitcnt`, and stay in SHIFT.
  - **PAD:** ignore bits DATA_W+1 up to SLOT_W. On `lr_edge`, latch the new channel, clear `bitcnt`, and go to SHIFT.
- **Edge-rise precedence:** the `lr_edge` rise is never shifted as data in any state.
- **Bit-count saturation:** `bitcnt` saturates at SLOT_W-1. An over-long slot gives no error and no extra output.
- **Reset:** while `rst_n`=0 at a rising `mclk`:
  - all outputs go to 0;
  - state returns to WAIT_SYNC;
  - `shreg`, `bitcnt` and `lr_q` clear, and synchroniser flops clear.
- **Reset mid-frame:** the word in flight is lost. No valid or error pulse is emitted during or immediately after reset.
- **Valid pulse width:** `l_valid` and `r_valid` never assert in the same cycle, and each is high for exactly one `mclk` cycle.

## Timing
- **Clock ratio:** SCLK high and low phases must each be ≥ 3 `mclk` periods. The codebase's SCLK = `mclk`/8 satisfies this.
- **Output latency:** let edge n be the first `mclk` edge that captures `sclk_i` high for the LSB (bit DATA_W) of a word. Then `l_dout`/`r_dout` and the valid pulse update at edge n+2, with valid high for the cycle after n+2.
- **`slot_err` latency:** `slot_err` has the same latency relative to the offending `lr_edge` rise.
- **Setup requirement:** `sdata_i` and `lrclk_i` must be stable ≥ 2 `mclk` periods before the SCLK rising edge. Standard I2S change-on-falling-edge meets this.
- **Throughput:** one sample per channel per LRCLK period. There is no backpressure; the consumer must take the sample before the next valid.

## Structure
- **Package `i2s_pkg`:** state enum (WAIT_SYNC, SHIFT, PAD), default DATA_W=16, SLOT_W=32, and the channel encoding LEFT=0 / RIGHT=1. The TX side uses the same package.
- **Sub-module `i2s_sync_edge`:** 2-FF synchroniser plus registered rising-edge detect, with synchronous active-low reset. Instantiated for `sclk`. `lrclk` and `sdata` use its synchroniser output only.
- **Top `i2s_rx`:** FSM, shift register, bit counter and output registers.

## Test plan
- **Basic frame:** after reset, send one dummy frame, then left 0xA5C3 and right 0x1234 (32-bit slots, SCLK = `mclk`/8).
  - `l_dout`=0xA5C3 with a single `l_valid` pulse, then `r_dout`=0x1234 with a single `r_valid` pulse.
  - `slot_err` stays 0.
- **Post-reset partial frame:** release reset mid-left-slot with data 0xFFFF.
  - No valid until the first LRCLK edge.
  - The next full right word 0x8001 appears as `r_dout`=0x8001.
- **Short slot:** LRCLK toggles after only 10 data bits.
  - `slot_err` pulses once, with no valid for that word.
  - The following full word 0x0F0F is received correctly.
- **Padding bits:** bits 17–32 of each slot are driven 1 while the word is 0x0000.
  - `l_dout`=0x0000, confirming the padding is ignored.
- **Reset mid-word:** assert `rst_n`=0 for 2 `mclk` cycles after 8 bits of the left word 0x1357.
  - Outputs read 0 and no valid for that word.
  - Reception resumes after the next LRCLK edge, with 0x2468 received intact.
- **Loop-back:** drive with our I2S TX model for 64 random sample pairs.
  - Every `l_dout`/`r_dout` matches its stimulus in order, with no `slot_err`.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the RX and TX sides.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2s_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int SLOT_W_DEF = 32;

    // Channel encoding carried on LRCLK
    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        SHIFT     = 2'd1,
        PAD       = 2'd2
    } i2s_state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// 2-FF synchroniser with a registered rising-edge detect on the synced level.
// Latency: q follows d after 2 clk edges; rise pulses for one cycle after the 2nd edge.
// Backpressure: none; free-running.
//
// Ports:
//   clk   - sampling clock
//   rst_n - synchronous active-low reset, clears all three flops
//   d     - asynchronous input
//   q     - synchronised level
//   rise  - one-cycle pulse on a 0->1 transition of q
module i2s_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~s3;

endmodule

// File: rtl/i2s_rx.sv
// I2S (Philips) slave receiver: de-serialises SCLK/LRCLK/SDATA into parallel L/R samples.
// Latency: sample + valid update 2 mclk edges after the edge that first captures SCLK high for the LSB.
// Backpressure: none; consumer must take each sample before the next valid pulse.
//
// Ports:
//   mclk            - system clock, all logic on its rising edge
//   rst_n           - synchronous active-low reset
//   sclk_i          - bit clock, asynchronous to mclk
//   lrclk_i         - word select, low = left, high = right
//   sdata_i         - serial data, MSB first
//   l_dout / r_dout - last complete left / right sample, held between updates
//   l_valid/r_valid - one-cycle strobe when the matching dout updates
//   slot_err        - one-cycle strobe when a half-frame ends before DATA_W bits arrived
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SLOT_W = SLOT_W_DEF
) (
    input  logic              mclk,
    input  logic              rst_n,
    input  logic              sclk_i,
    input  logic              lrclk_i,
    input  logic              sdata_i,
    output logic [DATA_W-1:0] l_dout,
    output logic [DATA_W-1:0] r_dout,
    output logic              l_valid,
    output logic              r_valid,
    output logic              slot_err
);

    localparam int              CNT_W     = $clog2(SLOT_W);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SLOT_W - 1);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic sclk_rise;
    logic sclk_lvl_unused;
    logic lr_s;
    logic lr_rise_unused;
    logic sd_s;
    logic sd_rise_unused;

    i2s_sync_edge u_sync_sclk (
        .clk   (mclk),
        .rst_n (rst_n),
        .d     (sclk_i),
        .q     (sclk_lvl_unused),
        .rise  (sclk_rise)
    );

    i2s_sync_edge u_sync_lrclk (
        .clk   (mclk),
        .rst_n (rst_n),
        .d     (lrclk_i),
        .q     (lr_s),
        .rise  (lr_rise_unused)
    );

    i2s_sync_edge u_sync_sdata (
        .clk   (mclk),
        .rst_n (rst_n),
        .d     (sdata_i),
        .q     (sd_s),
        .rise  (sd_rise_unused)
    );

    // ------------------------------------------------------------------
    // Channel-edge detection: LRCLK is only looked at on SCLK rises
    // ------------------------------------------------------------------
    logic lr_q;
    logic lr_edge;

    assign lr_edge = sclk_rise && (lr_s != lr_q);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    i2s_state_t       state;
    i2s_state_t       state_nxt;
    logic [CNT_W-1:0] bitcnt;
    logic             do_shift;
    logic             word_done;
    logic             do_pad;
    logic             err;

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state <= WAIT_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_SYNC: if (lr_edge)   state_nxt = SHIFT;
            SHIFT:     if (word_done) state_nxt = PAD;
            PAD:       if (lr_edge)   state_nxt = SHIFT;
            default:                  state_nxt = WAIT_SYNC;
        endcase
    end

    // The LRCLK-edge rise carries the previous word's last bit, so an
    // edge always pre-empts shifting; in SHIFT it also means the slot was short.
    always_comb begin
        do_shift  = 1'b0;
        word_done = 1'b0;
        do_pad    = 1'b0;
        err       = 1'b0;
        unique case (state)
            SHIFT: begin
                if (lr_edge) begin
                    err = 1'b1;
                end else if (sclk_rise) begin
                    do_shift  = 1'b1;
                    word_done = (bitcnt == LAST_DATA);
                end
            end
            PAD:     do_pad = sclk_rise & ~lr_edge;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: shift register, bit counter, output registers
    // ------------------------------------------------------------------
    logic              chan;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic [CNT_W-1:0]  bitcnt_inc;

    assign shreg_nxt  = {shreg[DATA_W-2:0], sd_s};
    // Over-long slots just park the counter; PAD ignores everything until the next edge
    assign bitcnt_inc = (bitcnt == CNT_MAX) ? bitcnt : bitcnt + 1'b1;

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            lr_q     <= 1'b0;
            chan     <= LEFT;
            shreg    <= '0;
            bitcnt   <= '0;
            l_dout   <= '0;
            r_dout   <= '0;
            l_valid  <= 1'b0;
            r_valid  <= 1'b0;
            slot_err <= 1'b0;
        end else begin
            l_valid  <= 1'b0;
            r_valid  <= 1'b0;
            slot_err <= err;

            if (sclk_rise) begin
                lr_q <= lr_s;
            end

            if (lr_edge) begin
                chan   <= lr_s;
                shreg  <= '0;
                bitcnt <= '0;
            end else if (do_shift) begin
                shreg  <= shreg_nxt;
                bitcnt <= bitcnt_inc;
                if (word_done) begin
                    if (chan == LEFT) begin
                        l_dout  <= shreg_nxt;
                        l_valid <= 1'b1;
                    end else begin
                        r_dout  <= shreg_nxt;
                        r_valid <= 1'b1;
                    end
                end
            end else if (do_pad) begin
                bitcnt <= bitcnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives Philips frames at SCLK = mclk/8 and
// compares captured samples, strobe counts and latencies with hand-computed values.
// Outputs are sampled on the falling mclk edge.
module tb_i2s_rx;

    localparam int DW = 16;
    localparam int SW = 32;
    localparam logic CH_L = 1'b0;
    localparam logic CH_R = 1'b1;

    logic          mclk    = 1'b0;
    logic          rst_n   = 1'b0;
    logic          sclk_i  = 1'b0;
    logic          lrclk_i = 1'b0;
    logic          sdata_i = 1'b0;
    logic [DW-1:0] l_dout;
    logic [DW-1:0] r_dout;
    logic          l_valid;
    logic          r_valid;
    logic          slot_err;

    i2s_rx #(.DATA_W(DW), .SLOT_W(SW)) dut (
        .mclk     (mclk),
        .rst_n    (rst_n),
        .sclk_i   (sclk_i),
        .lrclk_i  (lrclk_i),
        .sdata_i  (sdata_i),
        .l_dout   (l_dout),
        .r_dout   (r_dout),
        .l_valid  (l_valid),
        .r_valid  (r_valid),
        .slot_err (slot_err)
    );

    always #5 mclk = ~mclk;

    int n_chk  = 0;
    int n_pass = 0;
    int l_cnt  = 0;
    int r_cnt  = 0;
    int e_cnt  = 0;
    int exp_lc = 0;
    int exp_rc = 0;
    int exp_ec = 0;
    logic [DW-1:0] exp_l[$];
    logic [DW-1:0] exp_r[$];
    longint lsb_t   = 0;
    longint edge_t  = 0;
    longint l_vld_t = 0;
    longint r_vld_t = 0;
    longint err_t   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Output monitor: counts every strobe and checks captured data against the expected queues
    initial begin
        forever begin
            @(negedge mclk);
            if (l_valid) begin
                l_cnt++;
                l_vld_t = $time;
                if (exp_l.size() > 0) check("l_dout", {16'h0, l_dout}, {16'h0, exp_l.pop_front()});
            end
            if (r_valid) begin
                r_cnt++;
                r_vld_t = $time;
                if (exp_r.size() > 0) check("r_dout", {16'h0, r_dout}, {16'h0, exp_r.pop_front()});
            end
            if (l_valid || r_valid) check("valid_excl", {31'h0, l_valid & r_valid}, 32'h0);
            if (slot_err) begin
                e_cnt++;
                err_t = $time;
            end
        end
    end

    // One SCLK period: data and LRCLK change on the falling edge, 4 mclk low, 4 mclk high
    task automatic send_bit(input logic sd, input logic lr, output longint t_rise);
        sclk_i  = 1'b0;
        sdata_i = sd;
        lrclk_i = lr;
        repeat (4) @(negedge mclk);
        sclk_i = 1'b1;
        t_rise = $time;
        repeat (4) @(negedge mclk);
    endtask

    // One half-frame of sl rises. The first nd carry w MSB first, the rest carry pad.
    // LRCLK moves to nc on the final rise, so that rise is the next word's channel edge.
    // rst_at >= 0: after that rise either release reset (rel=1) or pulse it for 2 cycles.
    task automatic send_slot(input logic c, input logic nc, input logic [DW-1:0] w,
                             input int nd, input int sl, input logic pad,
                             input int rst_at, input bit rel);
        logic   b;
        longint t;
        for (int i = 0; i < sl; i++) begin
            b = (i < nd) ? w[nd-1-i] : pad;
            send_bit(b, (i == sl - 1) ? nc : c, t);
            if (i == nd - 1) lsb_t  = t;
            if (i == sl - 1) edge_t = t;
            if (i == rst_at) begin
                if (rel) begin
                    rst_n = 1'b1;
                end else begin
                    rst_n = 1'b0;
                    repeat (2) @(negedge mclk);
                    check("rst_l_dout",   {16'h0, l_dout}, 32'h0);
                    check("rst_r_dout",   {16'h0, r_dout}, 32'h0);
                    check("rst_l_valid",  {31'h0, l_valid}, 32'h0);
                    check("rst_r_valid",  {31'h0, r_valid}, 32'h0);
                    check("rst_slot_err", {31'h0, slot_err}, 32'h0);
                    rst_n = 1'b1;
                end
            end
        end
    endtask

    task automatic check_counts(input string ph);
        check({ph, "_l_cnt"}, l_cnt, exp_lc);
        check({ph, "_r_cnt"}, r_cnt, exp_rc);
        check({ph, "_err_cnt"}, e_cnt, exp_ec);
    endtask

    logic [DW-1:0] rl;
    logic [DW-1:0] rr;

    initial begin
        // Reset state
        repeat (4) @(negedge mclk);
        check("reset_l_dout",   {16'h0, l_dout}, 32'h0);
        check("reset_r_dout",   {16'h0, r_dout}, 32'h0);
        check("reset_l_valid",  {31'h0, l_valid}, 32'h0);
        check("reset_r_valid",  {31'h0, r_valid}, 32'h0);
        check("reset_slot_err", {31'h0, slot_err}, 32'h0);

        // Reset released mid-left-slot carrying 0xFFFF: nothing until the LRCLK edge
        send_slot(CH_L, CH_R, 16'hFFFF, DW, SW, 1'b0, 4, 1'b1);
        check_counts("partial");
        exp_r.push_back(16'h8001); exp_rc++;
        send_slot(CH_R, CH_L, 16'h8001, DW, SW, 1'b0, -1, 1'b0);
        check_counts("partial_r");

        // Basic frame with output latency: valid sampled 30 time units after the LSB rise
        exp_l.push_back(16'hA5C3); exp_lc++;
        send_slot(CH_L, CH_R, 16'hA5C3, DW, SW, 1'b0, -1, 1'b0);
        check("l_latency", 32'(l_vld_t - lsb_t), 32'd30);
        exp_r.push_back(16'h1234); exp_rc++;
        send_slot(CH_R, CH_L, 16'h1234, DW, SW, 1'b0, -1, 1'b0);
        check("r_latency", 32'(r_vld_t - lsb_t), 32'd30);
        check("basic_l_hold", {16'h0, l_dout}, 32'h0000A5C3);
        check_counts("basic");

        // Short left slot: 10 bits then the edge
        send_slot(CH_L, CH_R, 16'h02AA, 10, 11, 1'b0, -1, 1'b0);
        exp_ec++;
        check("err_latency", 32'(err_t - edge_t), 32'd30);
        exp_r.push_back(16'h0F0F); exp_rc++;
        send_slot(CH_R, CH_L, 16'h0F0F, DW, SW, 1'b0, -1, 1'b0);
        check_counts("short");

        // Padding bits driven high are ignored
        exp_l.push_back(16'h0000); exp_lc++;
        send_slot(CH_L, CH_R, 16'h0000, DW, SW, 1'b1, -1, 1'b0);
        exp_r.push_back(16'h5A5A); exp_rc++;
        send_slot(CH_R, CH_L, 16'h5A5A, DW, SW, 1'b1, -1, 1'b0);
        check("pad_l_dout", {16'h0, l_dout}, 32'h0);
        check_counts("pad");

        // Reset after 8 bits of left 0x1357: word lost, right 0x2468 intact
        send_slot(CH_L, CH_R, 16'h1357, DW, SW, 1'b0, 7, 1'b0);
        check_counts("rst_mid");
        exp_r.push_back(16'h2468); exp_rc++;
        send_slot(CH_R, CH_L, 16'h2468, DW, SW, 1'b0, -1, 1'b0);
        check("rst_l_after", {16'h0, l_dout}, 32'h0);
        check_counts("rst_resume");

        // Loop-back style stream of random pairs with random padding
        for (int k = 0; k < 64; k++) begin
            rl = DW'($urandom);
            rr = DW'($urandom);
            exp_l.push_back(rl); exp_lc++;
            send_slot(CH_L, CH_R, rl, DW, SW, 1'($urandom_range(1)), -1, 1'b0);
            exp_r.push_back(rr); exp_rc++;
            send_slot(CH_R, CH_L, rr, DW, SW, 1'($urandom_range(1)), -1, 1'b0);
        end
        repeat (8) @(negedge mclk);
        check_counts("loopback");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
